cordic_scheduler: RTL

CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

---
 rtl/cordic_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: round-robin front end that shares one CORDIC core between
// two requesters. Each accepted operation is issued to the core, held stable
// for LATENCY+1 cycles, and its result is presented on the response channel
// until the consumer takes it.
// Optional feature: define CORDIC_SCHED_PERF_EN to add the 32-bit busy_cycles
// counter output.
module cordic_scheduler #(
   parameter int N       = 32,
   parameter int LATENCY = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0][1:0]      req_select,
   input  logic [1:0][N-1:0]    req_x,
   input  logic [1:0][N-1:0]    req_y,
   input  logic [1:0][N-1:0]    req_angle,
   output logic                 core_enable,
   output logic [1:0]           core_select,
   output logic [N-1:0]         core_x,
   output logic [N-1:0]         core_y,
   output logic [N-1:0]         core_angle,
   input  logic [N-1:0]         core_x_out,
   input  logic [N-1:0]         core_y_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [N-1:0]         rsp_x,
   output logic [N-1:0]         rsp_y,
   output logic                 busy
`ifdef CORDIC_SCHED_PERF_EN
   ,
   output logic [31:0]          busy_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] LAT8 = 8'(LATENCY);

   state_t     state;
   state_t     next_state;
   logic [7:0] count;
   logic       last_grant;
   logic       grant_any;
   logic       grant_id;
   logic       capture;

   // Next-state, arbitration and handshake decode; grants are only made from IDLE
   // and are suppressed while reset is held so req_ready reads 0 during reset.
   always_comb begin
      next_state = state;
      grant_any  = 1'b0;
      grant_id   = 1'b0;
      req_ready  = 2'b00;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (reset && (req_valid != 2'b00)) begin
               grant_any  = 1'b1;
               if (req_valid == 2'b11)
                  grant_id = ~last_grant;
               else
                  grant_id = req_valid[1];
               req_ready  = grant_id ? 2'b10 : 2'b01;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            next_state = WAIT;
         end
         WAIT: begin
            if (count == LAT8) begin
               capture    = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            if (rsp_ready)
               next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Latency counter: restarts on grant so ISSUE sees 0, then counts every
   // ISSUE/WAIT cycle until it matches LATENCY.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= 8'd0;
      else if (grant_any)
         count <= 8'd0;
      else if ((state == ISSUE) || (state == WAIT))
         count <= count + 8'd1;
   end

   // Operand latch and round-robin memory; a reset points priority at requester 0
   // by pretending requester 1 was granted last.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant  <= 1'b1;
         rsp_id      <= 1'b0;
         core_select <= 2'b00;
         core_x      <= '0;
         core_y      <= '0;
         core_angle  <= '0;
      end else if (grant_any) begin
         last_grant  <= grant_id;
         rsp_id      <= grant_id;
         core_select <= req_select[grant_id];
         core_x      <= req_x[grant_id];
         core_y      <= req_y[grant_id];
         core_angle  <= req_angle[grant_id];
      end
   end

   // Result capture: core outputs are taken bit-exact on the final WAIT cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_x <= '0;
         rsp_y <= '0;
      end else if (capture) begin
         rsp_x <= core_x_out;
         rsp_y <= core_y_out;
      end
   end

   // State-decoded status outputs.
   always_comb begin
      core_enable = (state == ISSUE) || (state == WAIT);
      rsp_valid   = (state == DONE);
      busy        = (state != IDLE);
   end

`ifdef CORDIC_SCHED_PERF_EN
   // Busy-cycle counter; wraps naturally at 2^32.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         busy_cycles <= 32'd0;
      else if (busy)
         busy_cycles <= busy_cycles + 32'd1;
   end
`endif

endmodule
